// File: rtl/axis_log_replay_pkg.sv
// Shared types and constants for the AXI-stream capture/replay buffer.
package axis_log_replay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        REPLAY
    } state_t;

    localparam int DROPPED_W = 16;

    // Stored entry is {TLAST, TID, TDEST, TKEEP, TDATA}.
    function automatic int entry_width(input int data_width);
        return data_width + data_width / 8 + 3;
    endfunction

endpackage

// File: rtl/axis_log_replay_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with read enable.
module axis_log_replay_ram #(
    parameter int WIDTH      = 11,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_log_replay.sv
// Capture-and-replay buffer for the governor debug path.
// Optional continuous replay is enabled with the AXIS_LOG_REPLAY_LOOP_EN macro.
module axis_log_replay
    import axis_log_replay_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   cap_TDATA,
    input  logic [DATA_WIDTH/8-1:0] cap_TKEEP,
    input  logic                    cap_TDEST,
    input  logic                    cap_TID,
    input  logic                    cap_TLAST,
    input  logic                    cap_TVALID,
    output logic                    cap_TREADY,
    output logic [DATA_WIDTH-1:0]   rep_TDATA,
    output logic [DATA_WIDTH/8-1:0] rep_TKEEP,
    output logic                    rep_TDEST,
    output logic                    rep_TID,
    output logic                    rep_TLAST,
    output logic                    rep_TVALID,
    input  logic                    rep_TREADY,
    input  logic                    capture_en,
    input  logic                    replay_start,
    input  logic                    clear,
`ifdef AXIS_LOG_REPLAY_LOOP_EN
    input  logic                    replay_loop,
`endif
    output logic [DEPTH_LOG2:0]     count,
    output logic [DROPPED_W-1:0]    dropped,
    output logic                    busy
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = entry_width(DATA_WIDTH);
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
`ifdef AXIS_LOG_REPLAY_LOOP_EN
    localparam bit LOOP_BUILD = 1'b1;
    logic loop_on;
    assign loop_on = replay_loop;
`else
    localparam bit LOOP_BUILD = 1'b0;
    logic loop_on;
    assign loop_on = 1'b0;
`endif

    state_t                state;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [DEPTH_LOG2-1:0] last_idx;
    logic                  issue_active;
    logic                  mid_valid;
    logic [EW-1:0]         rd_data;
    logic                  cap_fire, wr_en, rep_fire, out_ready, rd_en;

    assign last_idx  = DEPTH_LOG2'(count - 1'b1);
    assign cap_fire  = (state == CAPTURE) && cap_TVALID && cap_TREADY;
    assign wr_en     = cap_fire && (count != FULL);
    assign rep_fire  = rep_TVALID && rep_TREADY;
    assign out_ready = !rep_TVALID || rep_TREADY;
    // The RAM output register is the middle pipeline stage; it only reloads
    // when it is empty or about to move into the output register.
    assign rd_en     = (state == REPLAY) && issue_active && (!mid_valid || out_ready);

    axis_log_replay_ram #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count[DEPTH_LOG2-1:0]),
        .wr_data ({cap_TLAST, cap_TID, cap_TDEST, cap_TKEEP, cap_TDATA}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            cap_TREADY   <= 1'b0;
            rep_TVALID   <= 1'b0;
            rep_TDATA    <= '0;
            rep_TKEEP    <= '0;
            rep_TDEST    <= 1'b0;
            rep_TID      <= 1'b0;
            rep_TLAST    <= 1'b0;
            count        <= '0;
            dropped      <= '0;
            busy         <= 1'b0;
            rd_ptr       <= '0;
            acc_idx      <= '0;
            issue_active <= 1'b0;
            mid_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        count   <= '0;
                        dropped <= '0;
                    end else if (replay_start) begin
                        if (count != '0) begin
                            state        <= REPLAY;
                            busy         <= 1'b1;
                            issue_active <= 1'b1;
                            rd_ptr       <= '0;
                            acc_idx      <= '0;
                        end
                    end else if (capture_en) begin
                        state      <= CAPTURE;
                        busy       <= 1'b1;
                        cap_TREADY <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (wr_en)
                        count <= count + 1'b1;
                    else if (cap_fire && dropped != '1)
                        dropped <= dropped + 1'b1;
                    if (!capture_en) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cap_TREADY <= 1'b0;
                    end
                end
                REPLAY: begin
                    if (rd_en) begin
                        if (rd_ptr == last_idx) begin
                            rd_ptr <= '0;
                            if (!LOOP_BUILD)
                                issue_active <= 1'b0;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                    if (rd_en)
                        mid_valid <= 1'b1;
                    else if (out_ready)
                        mid_valid <= 1'b0;
                    if (out_ready) begin
                        rep_TVALID <= mid_valid;
                        if (mid_valid) begin
                            rep_TDATA <= rd_data[DATA_WIDTH-1:0];
                            rep_TKEEP <= rd_data[DATA_WIDTH +: KW];
                            rep_TDEST <= rd_data[DATA_WIDTH+KW];
                            rep_TID   <= rd_data[DATA_WIDTH+KW+1];
                            rep_TLAST <= rd_data[DATA_WIDTH+KW+2];
                        end
                    end
                    if (rep_fire)
                        acc_idx <= (acc_idx == last_idx) ? '0 : acc_idx + 1'b1;
                    // Looping prefetches past the end; those beats are flushed here.
                    if (rep_fire && acc_idx == last_idx && !loop_on) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        rep_TVALID   <= 1'b0;
                        mid_valid    <= 1'b0;
                        issue_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_log_replay.sv
// Directed self-checking bench for axis_log_replay (main DUT depth 64, overflow DUT depth 4).
module tb_axis_log_replay;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  cap_TDATA;
    logic [0:0]  cap_TKEEP;
    logic        cap_TDEST, cap_TID, cap_TLAST, cap_TVALID;
    logic        rep_TREADY, capture_en, replay_start, clear, replay_loop;

    logic        a_cap_TREADY, a_rep_TDEST, a_rep_TID, a_rep_TLAST, a_rep_TVALID, a_busy;
    logic [7:0]  a_rep_TDATA;
    logic [0:0]  a_rep_TKEEP;
    logic [6:0]  a_count;
    logic [15:0] a_dropped;

    logic        b_cap_TREADY, b_rep_TDEST, b_rep_TID, b_rep_TLAST, b_rep_TVALID, b_busy;
    logic [7:0]  b_rep_TDATA;
    logic [0:0]  b_rep_TKEEP;
    logic [2:0]  b_count;
    logic [15:0] b_dropped;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_log_replay #(.DATA_WIDTH(8), .DEPTH_LOG2(6)) u_dut (
        .clk(clk), .aresetn(aresetn),
        .cap_TDATA(cap_TDATA), .cap_TKEEP(cap_TKEEP), .cap_TDEST(cap_TDEST), .cap_TID(cap_TID),
        .cap_TLAST(cap_TLAST), .cap_TVALID(cap_TVALID), .cap_TREADY(a_cap_TREADY),
        .rep_TDATA(a_rep_TDATA), .rep_TKEEP(a_rep_TKEEP), .rep_TDEST(a_rep_TDEST), .rep_TID(a_rep_TID),
        .rep_TLAST(a_rep_TLAST), .rep_TVALID(a_rep_TVALID), .rep_TREADY(rep_TREADY),
        .capture_en(capture_en), .replay_start(replay_start), .clear(clear),
`ifdef AXIS_LOG_REPLAY_LOOP_EN
        .replay_loop(replay_loop),
`endif
        .count(a_count), .dropped(a_dropped), .busy(a_busy)
    );

    axis_log_replay #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) u_ovf (
        .clk(clk), .aresetn(aresetn),
        .cap_TDATA(cap_TDATA), .cap_TKEEP(cap_TKEEP), .cap_TDEST(cap_TDEST), .cap_TID(cap_TID),
        .cap_TLAST(cap_TLAST), .cap_TVALID(cap_TVALID), .cap_TREADY(b_cap_TREADY),
        .rep_TDATA(b_rep_TDATA), .rep_TKEEP(b_rep_TKEEP), .rep_TDEST(b_rep_TDEST), .rep_TID(b_rep_TID),
        .rep_TLAST(b_rep_TLAST), .rep_TVALID(b_rep_TVALID), .rep_TREADY(rep_TREADY),
        .capture_en(capture_en), .replay_start(replay_start), .clear(clear),
`ifdef AXIS_LOG_REPLAY_LOOP_EN
        .replay_loop(replay_loop),
`endif
        .count(b_count), .dropped(b_dropped), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic dst, input logic id);
        cap_TVALID = 1'b1;
        cap_TDATA  = d;
        cap_TKEEP  = 1'b1;
        cap_TLAST  = l;
        cap_TDEST  = dst;
        cap_TID    = id;
        tick();
        cap_TVALID = 1'b0;
        cap_TLAST  = 1'b0;
        cap_TDEST  = 1'b0;
        cap_TID    = 1'b0;
    endtask

    task automatic pulse_start();
        replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
    endtask

    function automatic logic [11:0] a_entry();
        return {a_rep_TLAST, a_rep_TID, a_rep_TDEST, a_rep_TKEEP, a_rep_TDATA};
    endfunction

    logic [11:0] exp1 [5];
    logic [7:0]  exp_bp [5];
    int got;

    initial begin
        exp1 = '{12'h101, 12'h103, 12'h105, 12'h307, 12'hD09};
        exp_bp = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09};
        aresetn = 1'b0;
        cap_TDATA = '0; cap_TKEEP = '0; cap_TDEST = 1'b0; cap_TID = 1'b0; cap_TLAST = 1'b0;
        cap_TVALID = 1'b0; rep_TREADY = 1'b0; capture_en = 1'b0; replay_start = 1'b0;
        clear = 1'b0; replay_loop = 1'b0;
        tick(); tick();

        chk("rst_cap_ready", a_cap_TREADY, 0);
        chk("rst_rep_valid", a_rep_TVALID, 0);
        chk("rst_rep_data", a_entry(), 0);
        chk("rst_count", a_count, 0);
        chk("rst_dropped", a_dropped, 0);
        chk("rst_busy", a_busy, 0);
        aresetn = 1'b1;
        tick();

        // Basic capture of 5 beats, then single-pass replay with TREADY held high
        capture_en = 1'b1;
        tick();
        chk("cap_ready_up", a_cap_TREADY, 1);
        chk("cap_busy", a_busy, 1);
        send(8'h01, 0, 0, 0);
        send(8'h03, 0, 0, 0);
        send(8'h05, 0, 0, 0);
        send(8'h07, 0, 1, 0);
        send(8'h09, 1, 0, 1);
        chk("cap_count5", a_count, 5);
        capture_en = 1'b0;
        tick();
        chk("cap_idle_ready", a_cap_TREADY, 0);
        chk("cap_idle_busy", a_busy, 0);
        rep_TREADY = 1'b1;
        pulse_start();
        chk("rep_lat0", a_rep_TVALID, 0);
        chk("rep_busy", a_busy, 1);
        tick();
        chk("rep_lat1", a_rep_TVALID, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rep_valid", a_rep_TVALID, 1);
            chk("rep_entry", a_entry(), exp1[i]);
        end
        tick();
        chk("rep_end_valid", a_rep_TVALID, 0);
        chk("rep_end_busy", a_busy, 0);
        chk("rep_keeps_count", a_count, 5);

        // Replay the same buffer under random backpressure
        pulse_start();
        got = 0;
        for (int c = 0; c < 200 && got < 5; c++) begin
            rep_TREADY = 1'($urandom_range(0, 1));
            if (a_rep_TVALID) begin
                chk("bp_data", a_rep_TDATA, exp_bp[got]);
                chk("bp_last", a_rep_TLAST, (got == 4) ? 1 : 0);
                if (rep_TREADY) got++;
            end
            tick();
        end
        chk("bp_all_beats", got, 5);
        chk("bp_end_valid", a_rep_TVALID, 0);
        chk("bp_end_busy", a_busy, 0);
        rep_TREADY = 1'b1;

        // Overflow on the depth-4 instance
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count", a_count, 0);
        chk("clr_ovf_dropped", b_dropped, 0);
        capture_en = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), (i == 6), 0, 0);
        capture_en = 1'b0;
        tick();
        chk("ovf_count", b_count, 4);
        chk("ovf_dropped", b_dropped, 3);
        chk("ovf_main_count", a_count, 7);
        pulse_start();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf_valid", b_rep_TVALID, 1);
            chk("ovf_data", b_rep_TDATA, 8'h10 + 8'(i));
        end
        tick();
        chk("ovf_end_valid", b_rep_TVALID, 0);
        repeat (4) tick();
        chk("ovf_main_done", a_busy, 0);

        // clear beats replay_start in the same IDLE cycle
        clear = 1'b1;
        replay_start = 1'b1;
        tick();
        clear = 1'b0;
        replay_start = 1'b0;
        chk("prio_count", a_count, 0);
        chk("prio_busy", a_busy, 0);
        tick(); tick();
        chk("prio_no_valid", a_rep_TVALID, 0);

        // replay_start during CAPTURE is ignored
        capture_en = 1'b1;
        tick();
        send(8'hA1, 0, 0, 0);
        send(8'hA2, 1, 0, 0);
        pulse_start();
        chk("capstart_ready", a_cap_TREADY, 1);
        capture_en = 1'b0;
        tick();
        tick(); tick();
        chk("capstart_no_valid", a_rep_TVALID, 0);
        chk("capstart_count", a_count, 2);

        // replay_start wins over capture_en in IDLE
        capture_en = 1'b1;
        pulse_start();
        capture_en = 1'b0;
        chk("startwin_ready", a_cap_TREADY, 0);
        tick(); tick();
        chk("startwin_data", a_rep_TDATA, 8'hA1);
        tick();
        chk("startwin_data2", a_rep_TDATA, 8'hA2);
        tick();
        chk("startwin_done", a_busy, 0);

        // Asynchronous reset on the third replay beat
        clear = 1'b1;
        tick();
        clear = 1'b0;
        capture_en = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) send(8'(i), (i == 5), 0, 0);
        capture_en = 1'b0;
        tick();
        pulse_start();
        tick(); tick(); tick(); tick();
        chk("rst3_beat", a_rep_TDATA, 8'h03);
        aresetn = 1'b0;
        #1;
        chk("rst3_valid", a_rep_TVALID, 0);
        chk("rst3_count", a_count, 0);
        chk("rst3_busy", a_busy, 0);
        #2;
        aresetn = 1'b1;
        tick();

`ifdef AXIS_LOG_REPLAY_LOOP_EN
        // Loop mode: A,B,C repeated; dropping replay_loop during B ends after next C
        capture_en = 1'b1;
        tick();
        send(8'h0A, 0, 0, 0);
        send(8'h0B, 0, 0, 0);
        send(8'h0C, 1, 0, 0);
        capture_en = 1'b0;
        tick();
        replay_loop = 1'b1;
        pulse_start();
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("loop_valid", a_rep_TVALID, 1);
            chk("loop_data", a_rep_TDATA, 8'h0A + 8'(i % 3));
            if (i == 7) replay_loop = 1'b0;
        end
        tick();
        chk("loop_lastc", a_rep_TDATA, 8'h0C);
        tick();
        chk("loop_end_valid", a_rep_TVALID, 0);
        chk("loop_end_busy", a_busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_log_replay.md
# axis_log_replay

Capture-and-replay buffer for the governor debug path. It sinks the governor's log AXI stream into on-chip memory while capture is enabled. On command, it replays the stored beats, in order, onto an AXI stream that feeds the governor's inject port. Replay does not destroy the buffer, so one capture can be replayed many times.

## Interface
- DATA_WIDTH, 8: TDATA width in bits (multiple of 8); TKEEP is DATA_WIDTH/8.
- DEPTH_LOG2, 6: buffer holds 2^DEPTH_LOG2 beats.
- clk  in  1  Single clock; all logic rises on clk.
- aresetn  in  1  Reset, asynchronous assert, active-low.
- cap_TDATA / cap_TKEEP / cap_TDEST / cap_TID / cap_TLAST  in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1 / 1  Capture stream payload (from governor log_*).
- cap_TVALID  in  1  Capture beat valid.
- cap_TREADY  out  1  Capture ready.
- rep_TDATA / rep_TKEEP / rep_TDEST / rep_TID / rep_TLAST  out  same widths  Replay payload (to governor inj_*).
- rep_TVALID  out  1  Replay beat valid.
- rep_TREADY  in  1  Replay ready.
- capture_en  in  1  Level; enables capture.
- replay_start  in  1  Single-cycle pulse; starts replay.
- clear  in  1  Single-cycle pulse; empties the buffer.
- count  out  DEPTH_LOG2+1  Number of beats stored.
- dropped  out  16  Beats discarded while full; saturates at 0xFFFF.
- busy  out  1  High in CAPTURE or REPLAY.

## Operation
- Stored entry is {TLAST, TID, TDEST, TKEEP, TDATA}, i.e. DATA_WIDTH + DATA_WIDTH/8 + 3 bits.
- FSM has three states: IDLE, CAPTURE, REPLAY.
- IDLE -> CAPTURE when capture_en = 1 and clear = 0.
- CAPTURE -> IDLE when capture_en = 0.
- IDLE -> REPLAY on replay_start when count > 0. replay_start with count = 0 is ignored.
- REPLAY -> IDLE when the beat at index count-1 is accepted on rep_*.
- CAPTURE behaviour:
  - cap_TREADY = 1 at all times, so the governor log path is never stalled.
  - An accepted beat is written at index count and count increments.
  - When count = 2^DEPTH_LOG2, accepted beats are discarded and dropped increments, saturating.
- REPLAY behaviour:
  - Read index starts at 0 and advances on each rep_TVALID && rep_TREADY.
  - count is unchanged by replay.
- Input priority:
  - clear is honoured only in IDLE; it zeroes count and dropped.
  - If clear and replay_start arrive in the same cycle, clear wins and no replay starts.
  - replay_start and clear are ignored in CAPTURE and REPLAY.
  - capture_en is ignored in IDLE while replay_start is also high; replay wins.
- Reset values: cap_TREADY = 0, rep_TVALID = 0, rep_* payload = 0, count = 0, dropped = 0, busy = 0, state = IDLE.
- Reset asserted mid-capture or mid-replay returns all of the above immediately. Memory contents are don't-care after reset.

## Timing
- cap_TREADY is registered; it goes high on the edge after capture_en is sampled high in IDLE.
- Memory is synchronous-read with a 1-cycle read latency. Replay output is taken from a registered output stage with prefetch.
- First rep_TVALID rises 2 cycles after the edge that samples replay_start.
- Throughput is 1 beat per cycle under continuous rep_TREADY; there are no bubbles between beats.
- AXI rules on rep_*:
  - Once asserted, rep_TVALID stays high until accepted.
  - Payload is stable while rep_TVALID && !rep_TREADY.
  - rep_TVALID never depends combinationally on rep_TREADY.
- count updates on the edge that accepts a capture beat.
- dropped updates on the edge that discards a beat.

## Configuration
- AXIS_LOG_REPLAY_LOOP_EN defined:
  - Adds input port replay_loop (1 bit).
  - In REPLAY with replay_loop = 1, after index count-1 is accepted the read index wraps to 0 with no bubble, and the state stays REPLAY.
  - Dropping replay_loop ends replay after the current pass completes.
- Macro undefined: replay_loop is absent and replay is always a single pass.

## Structure
- Package axis_log_replay_pkg holds:
  - the state enum (IDLE, CAPTURE, REPLAY);
  - the entry-width function of DATA_WIDTH;
  - DROPPED_W = 16.
- Sub-module axis_log_replay_ram: simple dual-port RAM with one write port and one synchronous-read port, depth 2^DEPTH_LOG2, inferable as BRAM/LUTRAM.

## Test plan
- Basic capture and replay:
  - Stimulus: capture 5 beats with TDATA 1,3,5,7,9 and TLAST on the last; drop capture_en; pulse replay_start; hold rep_TREADY = 1.
  - Response: count = 5; rep_* emits 1,3,5,7,9 in 5 consecutive cycles starting 2 cycles after the pulse, TLAST only on 9; busy falls after the final beat.
- Random backpressure:
  - Stimulus: same 5-beat capture, with rep_TREADY randomised at 50%.
  - Response: identical sequence; payload stable whenever stalled.
- Overflow:
  - Stimulus: DEPTH_LOG2 = 2; capture 7 beats.
  - Response: count = 4, dropped = 3; replay emits only the first 4 beats.
- Input priority:
  - Stimulus: clear and replay_start in the same IDLE cycle.
  - Response: count = 0, no rep_TVALID. replay_start pulsed during CAPTURE is ignored.
- Reset mid-replay:
  - Stimulus: assert aresetn = 0 on the 3rd replay beat.
  - Response: rep_TVALID = 0, count = 0, busy = 0 within the same cycle.
- Loop mode (AXIS_LOG_REPLAY_LOOP_EN, replay_loop = 1, 3 beats A,B,C):
  - Response: A,B,C,A,B,C,... with no bubble. Dropping replay_loop during B ends after the following C.
